// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit: access-size
// encodings, the controller state type and the size-to-byte-count mapping.
package lsu_pkg;

  // Access size encodings as carried on req_size.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // Controller states.
  //   IDLE  : waiting for a CPU request (req_ready high)
  //   ISSUE : presenting byte transactions to memory, one per grant
  //   DRAIN : loads only, all bytes granted, waiting for the last read byte
  //   RESP  : one-cycle response pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Number of byte transactions for a given access size. The illegal size
  // maps to 0; such requests never leave IDLE for ISSUE.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_byte_serial_if.sv
// Bundle of the CPU request/response channel and the byte-wide memory port
// of the load/store unit.
//
// Handshake semantics:
//   - CPU request: a transfer happens in a cycle where req_valid && req_ready
//     are both high at the rising clock edge. req_ready does not depend on
//     req_valid. resp_valid is a single-cycle pulse with no backpressure.
//   - Memory: a byte transfer happens in a cycle where mem_req && mem_gnt
//     are both high. While mem_gnt is low, mem_req and the address/data/we
//     signals stay asserted and unchanged. For a granted read, mem_rvalid
//     and mem_rdata are presented exactly one cycle later.
//
// Modports:
//   slave  : the load/store unit itself
//   master : the environment around it (pipeline stage plus data memory)
interface lsu_byte_serial_if #(
  parameter int ADDR_W = 32
);

  // CPU request / response
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_exception;

  // Byte-wide data memory port
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_exception,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_write, req_size, req_sign, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_exception,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_extend.sv
// Zero/sign extension of the assembled little-endian load value according
// to the access size. Purely combinational.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] ext_o
);

  // Select the extension point (bit 7, 15 or 31) from the access size.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_BYTE: ext_o = {{24{sign_i & raw_i[7]}},  raw_i[7:0]};
      SIZE_HALF: ext_o = {{16{sign_i & raw_i[15]}}, raw_i[15:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit. Accepts one CPU load/store at a time, checks
// size/alignment, runs the access as 1, 2 or 4 single-byte memory
// transactions, assembles read bytes little-endian, extends the result and
// returns a one-cycle response pulse.
//
// Build option: define LSU_UNALIGNED_EN to allow misaligned halfword/word
// accesses (they proceed byte-serially from req_addr, wrapping modulo
// 2^ADDR_W). Without it, misaligned halfword/word accesses raise
// resp_exception. The illegal size always raises resp_exception.
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  lsu_byte_serial_if.slave    bus,
  output state_e              dbg_state_o
);

  // Controller state
  state_e state_q, state_d;

  // Request captured at acceptance
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              write_q;
  logic              exc_q;
  logic [2:0]        n_q;

  // Independent issue (k) and receive (j) byte counters, so a new byte can
  // be issued in the same cycle an earlier one returns.
  logic [2:0]        issue_q;
  logic [2:0]        recv_q;

  // Little-endian assembly register for load data
  logic [31:0]       asm_q;

  // Decoded events
  logic              accept;
  logic              req_exc;
  logic              issue_fire;
  logic              last_issue;
  logic              recv_fire;
  logic              last_recv;
  logic [31:0]       ext_data;

  // Acceptance and exception decode for the incoming request.
  always_comb begin
    accept  = (state_q == IDLE) && bus.req_valid;
`ifdef LSU_UNALIGNED_EN
    req_exc = (bus.req_size == SIZE_ILL);
`else
    req_exc = (bus.req_size == SIZE_ILL)
           || ((bus.req_size == SIZE_HALF) && bus.req_addr[0])
           || ((bus.req_size == SIZE_WORD) && (bus.req_addr[1:0] != 2'b00));
`endif
  end

  // Byte issue/receive events. Read data is only taken for loads while a
  // transfer is in progress and not all bytes have arrived yet.
  always_comb begin
    issue_fire = (state_q == ISSUE) && bus.mem_gnt;
    last_issue = issue_fire && (issue_q == (n_q - 3'd1));
    recv_fire  = ((state_q == ISSUE) || (state_q == DRAIN)) && !write_q
              && bus.mem_rvalid && (recv_q < n_q);
    last_recv  = recv_fire && (recv_q == (n_q - 3'd1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = req_exc ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_d = write_q ? RESP : DRAIN;
        end
      end
      DRAIN: begin
        if (last_recv) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, byte counters and load-data assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_BYTE;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      exc_q   <= 1'b0;
      n_q     <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      asm_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        sign_q  <= bus.req_sign;
        write_q <= bus.req_write;
        exc_q   <= req_exc;
        n_q     <= size_bytes(bus.req_size);
        issue_q <= '0;
        recv_q  <= '0;
        asm_q   <= '0;
      end
      if (issue_fire) begin
        issue_q <= issue_q + 3'd1;
      end
      if (recv_fire) begin
        asm_q[{recv_q[1:0], 3'b000} +: 8] <= bus.mem_rdata;
        recv_q <= recv_q + 3'd1;
      end
    end
  end

  // Extension of the assembled load value.
  lsu_extend u_extend (
    .raw_i  (asm_q),
    .size_i (size_q),
    .sign_i (sign_q),
    .ext_o  (ext_data)
  );

  // Output decode: memory port is driven only in ISSUE and held stable
  // there until the grant; responses are driven only in RESP.
  always_comb begin
    bus.req_ready      = (state_q == IDLE);
    bus.mem_req        = (state_q == ISSUE);
    bus.mem_we         = (state_q == ISSUE) && write_q;
    bus.mem_addr       = '0;
    bus.mem_wdata      = '0;
    if (state_q == ISSUE) begin
      bus.mem_addr = addr_q + ADDR_W'(issue_q);
      if (write_q) begin
        bus.mem_wdata = wdata_q[{issue_q[1:0], 3'b000} +: 8];
      end
    end
    bus.resp_valid     = (state_q == RESP);
    bus.resp_exception = (state_q == RESP) && exc_q;
    bus.resp_rdata     = '0;
    if ((state_q == RESP) && !exc_q && !write_q) begin
      bus.resp_rdata = ext_data;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial. Expected memory transactions and
// responses (with their cycle of appearance) are queued when a request is
// driven and compared by a negedge monitor when the DUT produces them.
// A small read responder returns bytes one cycle after each granted read.
module tb_lsu_byte_serial;
  import lsu_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;
  int     cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // {cycle[31:0], we, addr[31:0], wdata[7:0]}
  logic [72:0] mem_exp_q[$];
  // {cycle[31:0], exception, rdata[31:0]}
  logic [64:0] resp_exp_q[$];

  lsu_byte_serial_if #(.ADDR_W(32)) bus ();

  lsu_byte_serial #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    check(tag, {63'd0, cond}, 64'd1);
  endtask

  // Memory contents seen by loads.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a == 32'h202) return 8'h34;
    if (a == 32'h203) return 8'h80;
    return a[7:0] ^ 8'hA5;
  endfunction

  // ---------------- read responder ----------------
  initial begin
    logic       nxt_v;
    logic [7:0] nxt_d;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      nxt_v = (bus.mem_req === 1'b1) && bus.mem_gnt && (bus.mem_we === 1'b0);
      nxt_d = nxt_v ? mem_byte(bus.mem_addr) : 8'h00;
      @(posedge clk);
      #1;
      bus.mem_rvalid = nxt_v;
      bus.mem_rdata  = nxt_d;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [72:0] me;
    logic [64:0] re;
    if ((bus.mem_req === 1'b1) && (bus.mem_gnt === 1'b1)) begin
      check_true("mem_expected", mem_exp_q.size() != 0);
      if (mem_exp_q.size() != 0) begin
        me = mem_exp_q.pop_front();
        check("mem_cycle", 64'(cyc), 64'(me[72:41]));
        check("mem_we", {63'd0, bus.mem_we}, {63'd0, me[40]});
        check("mem_addr", 64'(bus.mem_addr), 64'(me[39:8]));
        if (me[40]) begin
          check("mem_wdata", 64'(bus.mem_wdata), 64'(me[7:0]));
        end
      end
    end
    if (bus.resp_valid === 1'b1) begin
      check_true("resp_expected", resp_exp_q.size() != 0);
      if (resp_exp_q.size() != 0) begin
        re = resp_exp_q.pop_front();
        check("resp_cycle", 64'(cyc), 64'(re[64:33]));
        check("resp_exception", {63'd0, bus.resp_exception}, {63'd0, re[32]});
        check("resp_rdata", 64'(bus.resp_rdata), 64'(re[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_mem(input int c, input logic we, input logic [31:0] a, input logic [7:0] d);
    mem_exp_q.push_back({c[31:0], we, a, d});
  endtask

  task automatic push_resp(input int c, input logic exc, input logic [31:0] d);
    resp_exp_q.push_back({c[31:0], exc, d});
  endtask

  // Presents one request for a single cycle; t returns the request cycle T.
  task automatic drive_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d, output int t);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_sign  = sg;
    bus.req_addr  = a;
    bus.req_wdata = d;
    t = cyc;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Expected byte reads for a load with the grant held high.
  task automatic push_load_bytes(input int t, input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      push_mem(t + 1 + k, 1'b0, a + k, 8'h00);
    end
  endtask

  task automatic wait_done(input string tag);
    int b = 0;
    while ((mem_exp_q.size() != 0 || resp_exp_q.size() != 0) && b < 40) begin
      @(posedge clk);
      b++;
    end
    check_true({tag, "_done"}, (mem_exp_q.size() == 0) && (resp_exp_q.size() == 0));
    mem_exp_q.delete();
    resp_exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = SIZE_BYTE;
    bus.req_sign  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_gnt   = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_resp_exc", {63'd0, bus.resp_exception}, 64'd0);
    check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store 0xDEADBEEF at 0x100
    drive_req(1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, t);
    push_mem(t + 1, 1'b1, 32'h100, 8'hEF);
    push_mem(t + 2, 1'b1, 32'h101, 8'hBE);
    push_mem(t + 3, 1'b1, 32'h102, 8'hAD);
    push_mem(t + 4, 1'b1, 32'h103, 8'hDE);
    push_resp(t + 5, 1'b0, 32'h0);
    wait_done("word_store");

    // Signed / unsigned halfword loads at 0x202 (bytes 0x34, 0x80)
    drive_req(1'b0, SIZE_HALF, 1'b1, 32'h202, 32'h0, t);
    push_load_bytes(t, 32'h202, 2);
    push_resp(t + 4, 1'b0, 32'hFFFF8034);
    wait_done("half_load_s");
    drive_req(1'b0, SIZE_HALF, 1'b0, 32'h202, 32'h0, t);
    push_load_bytes(t, 32'h202, 2);
    push_resp(t + 4, 1'b0, 32'h00008034);
    wait_done("half_load_u");

    // Aligned word load at 0x200
    drive_req(1'b0, SIZE_WORD, 1'b1, 32'h200, 32'h0, t);
    push_load_bytes(t, 32'h200, 4);
    push_resp(t + 6, 1'b0, 32'h8034A4A5);
    wait_done("word_load");

    // Misaligned word load at 0x101
    drive_req(1'b0, SIZE_WORD, 1'b0, 32'h101, 32'h0, t);
`ifdef LSU_UNALIGNED_EN
    push_load_bytes(t, 32'h101, 4);
    push_resp(t + 6, 1'b0, 32'hA1A6A7A4);
`else
    push_resp(t + 1, 1'b1, 32'h0);
    @(negedge clk);
    check("misal_word_no_req", {63'd0, bus.mem_req}, 64'd0);
`endif
    wait_done("misal_word");

    // Misaligned signed halfword load at 0x201
    drive_req(1'b0, SIZE_HALF, 1'b1, 32'h201, 32'h0, t);
`ifdef LSU_UNALIGNED_EN
    push_load_bytes(t, 32'h201, 2);
    push_resp(t + 4, 1'b0, 32'h000034A4);
`else
    push_resp(t + 1, 1'b1, 32'h0);
`endif
    wait_done("misal_half");

    // Byte store with the grant withheld for 3 cycles
    bus.mem_gnt = 1'b0;
    drive_req(1'b1, SIZE_BYTE, 1'b0, 32'h40, 32'h12345677, t);
    push_mem(t + 4, 1'b1, 32'h40, 8'h77);
    push_resp(t + 5, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_mem_req", {63'd0, bus.mem_req}, 64'd1);
      check("stall_mem_we", {63'd0, bus.mem_we}, 64'd1);
      check("stall_mem_addr", 64'(bus.mem_addr), 64'h40);
      check("stall_mem_wdata", 64'(bus.mem_wdata), 64'h77);
      @(posedge clk);
      #1;
    end
    bus.mem_gnt = 1'b1;
    wait_done("stall_store");

    // Halfword store at 0x10
    drive_req(1'b1, SIZE_HALF, 1'b0, 32'h10, 32'hCAFEF00D, t);
    push_mem(t + 1, 1'b1, 32'h10, 8'h0D);
    push_mem(t + 2, 1'b1, 32'h11, 8'hF0);
    push_resp(t + 3, 1'b0, 32'h0);
    wait_done("half_store");

    // Reset during a word load after two grants; no response may follow
    drive_req(1'b0, SIZE_WORD, 1'b0, 32'h300, 32'h0, t);
    push_load_bytes(t, 32'h300, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    check("midrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    repeat (6) @(posedge clk);
    wait_done("midrst");

    // Byte loads after the abort: signed and unsigned
    drive_req(1'b0, SIZE_BYTE, 1'b1, 32'h3, 32'h0, t);
    push_load_bytes(t, 32'h3, 1);
    push_resp(t + 3, 1'b0, 32'hFFFFFFA6);
    wait_done("byte_load_s");
    drive_req(1'b0, SIZE_BYTE, 1'b0, 32'h7F, 32'h0, t);
    push_load_bytes(t, 32'h7F, 1);
    push_resp(t + 3, 1'b0, 32'h000000DA);
    wait_done("byte_load_u");

    // Illegal size store: exception, no memory writes
    drive_req(1'b1, SIZE_ILL, 1'b0, 32'h80, 32'h55AA55AA, t);
    push_resp(t + 1, 1'b1, 32'h0);
    @(negedge clk);
    check("ill_no_req", {63'd0, bus.mem_req}, 64'd0);
    wait_done("ill_store");

    repeat (3) @(posedge clk);
    check_true("queues_empty", (mem_exp_q.size() == 0) && (resp_exp_q.size() == 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
